kd_tree_query_ctrl: RTL and testbench

Sequencer wrapped around internal_node_tree. It runs the tree's node-load phase: fsm_enable is held while aggregated node words stream in, and the beats are counted to completion. It then admits patch queries from one requester over valid/ready, drives the tree's pipelined patch port and returns leaf indices in order with the requester's query ID. The tree cannot stall, so the block bounds in-flight queries with credits.

---
 rtl/kd_tree_query_ctrl.sv | 175 +++++++++++++++++
 tb/tb_kd_tree_query_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_query_ctrl.sv
// Load/query sequencer for internal_node_tree: counts node-load beats, admits credit-bounded patch
// queries and returns leaf indices in order with their IDs. Optional: QUERY_PERF_CNT_EN perf counters.
module kd_tree_query_ctrl #(
    parameter int NUM_NODES     = 63,
    parameter int PATCH_WIDTH   = 55,
    parameter int ADDRESS_WIDTH = 8,
    parameter int ID_WIDTH      = 4,
    parameter int RES_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     node_wr_en,
    output logic                     fsm_enable,
    output logic                     load_done,
    output logic                     busy,
    input  logic                     query_valid,
    output logic                     query_ready,
    input  logic [PATCH_WIDTH-1:0]   query_patch,
    input  logic [ID_WIDTH-1:0]      query_id,
    output logic                     tree_patch_en,
    output logic [PATCH_WIDTH-1:0]   tree_patch,
    input  logic                     tree_leaf_valid,
    input  logic [ADDRESS_WIDTH-1:0] tree_leaf_index,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ADDRESS_WIDTH-1:0] res_leaf,
    output logic [ID_WIDTH-1:0]      res_id,
    output logic                     error
`ifdef QUERY_PERF_CNT_EN
    ,
    output logic [31:0]              query_count,
    output logic [$clog2(RES_DEPTH):0] max_inflight
`endif
);
    localparam int NC_W  = $clog2(NUM_NODES + 1);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RW_W  = ADDRESS_WIDTH + ID_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t                   state_q, state_d;
    logic [NC_W-1:0]          node_cnt_q, node_cnt_d;
    logic [CNT_W-1:0]         infl_q, infl_d, res_cnt_q, res_cnt_d;
    logic [PTR_W-1:0]         id_wr_q, id_rd_q, res_wr_q, res_rd_q;
    logic [ID_WIDTH-1:0]      id_mem  [RES_DEPTH];
    logic [RW_W-1:0]          res_mem [RES_DEPTH];
    logic                     patch_en_q, load_done_q, error_q;
    logic [PATCH_WIDTH-1:0]   patch_q;
    logic [CNT_W:0]           used;
    logic                     accept, leaf_ok, res_pop, last_beat, load_enter;
    logic [RW_W-1:0]          res_word;

    assign accept    = query_valid && query_ready;
    assign leaf_ok   = tree_leaf_valid && (infl_q != '0);
    assign res_pop   = res_valid && res_ready;
    assign used      = {1'b0, infl_q} + {1'b0, res_cnt_q};
    assign last_beat = (state_q == LOAD) && node_wr_en && (node_cnt_q == NC_W'(NUM_NODES - 1));

    assign fsm_enable    = (state_q == LOAD);
    assign load_done     = load_done_q;
    assign busy          = (state_q == LOAD) || (infl_q != '0) || (res_cnt_q != '0);
    assign query_ready   = (state_q == READY) && (used < (CNT_W + 1)'(RES_DEPTH));
    assign tree_patch_en = patch_en_q;
    assign tree_patch    = patch_q;
    assign error         = error_q;

    // Gate the unreset storage so the result port reads 0 whenever the FIFO is empty.
    assign res_valid = (res_cnt_q != '0);
    assign res_word  = res_valid ? res_mem[res_rd_q] : '0;
    assign res_leaf  = res_word[RW_W-1:ID_WIDTH];
    assign res_id    = res_word[ID_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        node_cnt_d = node_cnt_q;
        load_enter = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    node_cnt_d = '0;
                    load_enter = 1'b1;
                end
            end
            LOAD: begin
                if (node_wr_en) node_cnt_d = node_cnt_q + NC_W'(1);
                if (last_beat)  state_d    = READY;
            end
            READY: begin
                if (start && !busy) begin
                    state_d    = LOAD;
                    node_cnt_d = '0;
                    load_enter = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        infl_d = infl_q;
        case ({accept, leaf_ok})
            2'b10:   infl_d = infl_q + CNT_W'(1);
            2'b01:   infl_d = infl_q - CNT_W'(1);
            default: infl_d = infl_q;
        endcase
        res_cnt_d = res_cnt_q;
        case ({leaf_ok, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + CNT_W'(1);
            2'b01:   res_cnt_d = res_cnt_q - CNT_W'(1);
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            node_cnt_q  <= '0;
            infl_q      <= '0;
            res_cnt_q   <= '0;
            id_wr_q     <= '0;
            id_rd_q     <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            patch_en_q  <= 1'b0;
            patch_q     <= '0;
            load_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            node_cnt_q  <= node_cnt_d;
            infl_q      <= infl_d;
            res_cnt_q   <= res_cnt_d;
            patch_en_q  <= accept;
            load_done_q <= last_beat;
            if (accept)  patch_q  <= query_patch;
            if (accept)  id_wr_q  <= id_wr_q + PTR_W'(1);
            if (leaf_ok) id_rd_q  <= id_rd_q + PTR_W'(1);
            if (leaf_ok) res_wr_q <= res_wr_q + PTR_W'(1);
            if (res_pop) res_rd_q <= res_rd_q + PTR_W'(1);
            if ((node_wr_en && state_q != LOAD) || (tree_leaf_valid && infl_q == '0))
                error_q <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; the counters and pointers alone define their validity.
    always_ff @(posedge clk) begin
        if (accept)  id_mem[id_wr_q]   <= query_id;
        if (leaf_ok) res_mem[res_wr_q] <= {tree_leaf_index, id_mem[id_rd_q]};
    end

`ifdef QUERY_PERF_CNT_EN
    logic [31:0]      qcnt_q;
    logic [CNT_W-1:0] max_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt_q <= '0;
            max_q  <= '0;
        end else if (load_enter) begin
            qcnt_q <= '0;
            max_q  <= '0;
        end else begin
            if (res_pop)        qcnt_q <= qcnt_q + 32'd1;
            if (infl_d > max_q) max_q  <= infl_d;
        end
    end

    assign query_count  = qcnt_q;
    assign max_inflight = max_q;
`endif
endmodule

// File: tb/tb_kd_tree_query_ctrl.sv
// Directed bench for kd_tree_query_ctrl; the bench plays both requester and tree.
module tb_kd_tree_query_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, node_wr_en, fsm_enable, load_done, busy;
    logic        query_valid, query_ready;
    logic [54:0] query_patch, tree_patch;
    logic [3:0]  query_id, res_id;
    logic        tree_patch_en, tree_leaf_valid, res_valid, res_ready, error;
    logic [7:0]  tree_leaf_index, res_leaf;
`ifdef QUERY_PERF_CNT_EN
    logic [31:0] query_count;
    logic [2:0]  max_inflight;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kd_tree_query_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .node_wr_en(node_wr_en),
        .fsm_enable(fsm_enable), .load_done(load_done), .busy(busy),
        .query_valid(query_valid), .query_ready(query_ready),
        .query_patch(query_patch), .query_id(query_id),
        .tree_patch_en(tree_patch_en), .tree_patch(tree_patch),
        .tree_leaf_valid(tree_leaf_valid), .tree_leaf_index(tree_leaf_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_leaf(res_leaf),
        .res_id(res_id), .error(error)
`ifdef QUERY_PERF_CNT_EN
        , .query_count(query_count), .max_inflight(max_inflight)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [54:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {11'(a), 11'(b), 11'(c), 11'(d), 11'(e)};
    endfunction

    task automatic load_nodes();
        logic ok;
        ok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_fsm_en", fsm_enable, 1);
        check("load_qready", query_ready, 0);
        for (int i = 0; i < 63; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                if (!fsm_enable || load_done) ok = 1'b0;
                tick();
            end
            if (!fsm_enable || load_done) ok = 1'b0;
            node_wr_en = 1'b1;
            tick();
            node_wr_en = 1'b0;
            if (i < 62 && (!fsm_enable || load_done)) ok = 1'b0;
        end
        check("load_fsm_en_held", ok, 1);
        check("load_end_fsm_en", fsm_enable, 0);
        check("load_done_pulse", load_done, 1);
        tick();
        check("load_done_once", load_done, 0);
    endtask

    task automatic send(input logic [54:0] p, input logic [3:0] id);
        query_valid = 1'b1;
        query_patch = p;
        query_id    = id;
        check("send_qready", query_ready, 1);
        tick();
        query_valid = 1'b0;
        check("send_patch_en", tree_patch_en, 1);
        check("send_patch", tree_patch, p);
        tick();
        check("send_patch_en_off", tree_patch_en, 0);
        check("send_patch_hold", tree_patch, p);
    endtask

    task automatic leaf(input logic [7:0] idx);
        tree_leaf_valid = 1'b1;
        tree_leaf_index = idx;
        tick();
        tree_leaf_valid = 1'b0;
    endtask

    task automatic pop(input logic [7:0] exp_leaf, input logic [3:0] exp_id);
        check("pop_valid", res_valid, 1);
        check("pop_leaf", res_leaf, exp_leaf);
        check("pop_id", res_id, exp_id);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        logic [54:0] pa, pb, pc;
        int acc;
        rst = 1'b1; start = 1'b0; node_wr_en = 1'b0; query_valid = 1'b0;
        query_patch = '0; query_id = '0; tree_leaf_valid = 1'b0;
        tree_leaf_index = '0; res_ready = 1'b0;
        tick(); tick();
        check("rst_fsm_en", fsm_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_qready", query_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_patch", tree_patch, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        tick();

        load_nodes();
        node_wr_en = 1'b1;
        tick();
        node_wr_en = 1'b0;
        check("extra_beat_error", error, 1);
        rst = 1'b1;
        tick();
        check("rst_clears_error", error, 0);
        rst = 1'b0;
        tick();
        load_nodes();
        check("ready_qready", query_ready, 1);

        send(pk(251, -26, -1, -88, 79), 4'd3);
        leaf(8'd59);
        pop(8'd59, 4'd3);
        send(pk(279, -18, -55, -22, 18), 4'd4);
        leaf(8'd60);
        pop(8'd60, 4'd4);
        check("single_drained", res_valid, 0);

        pa = pk(-72, -213, 201, 45, 235);
        pb = pk(-245, -199, 45, 58, 177);
        pc = pk(-50, -64, -298, 245, -141);
        query_valid = 1'b1; query_patch = pa; query_id = 4'd1;
        tick();
        check("b2b_en_a", tree_patch_en, 1);
        check("b2b_patch_a", tree_patch, pa);
        query_patch = pb; query_id = 4'd2;
        tick();
        check("b2b_en_b", tree_patch_en, 1);
        check("b2b_patch_b", tree_patch, pb);
        query_patch = pc; query_id = 4'd3;
        tick();
        query_valid = 1'b0;
        check("b2b_en_c", tree_patch_en, 1);
        check("b2b_patch_c", tree_patch, pc);
        tick();
        check("b2b_en_off", tree_patch_en, 0);
        leaf(8'd22); leaf(8'd5); leaf(8'd24);
        pop(8'd22, 4'd1); pop(8'd5, 4'd2); pop(8'd24, 4'd3);
        check("b2b_drained", res_valid, 0);
        check("b2b_idle", busy, 0);

        acc = 0;
        query_valid = 1'b1; query_id = 4'd0; query_patch = pa;
        for (int c = 0; c < 7; c++) begin
            if (query_ready) acc++;
            tick();
            query_id = 4'(acc);
        end
        check("credit_accepts", acc, 4);
        check("credit_qready_low", query_ready, 0);
        query_valid = 1'b0;
        for (int k = 0; k < 4; k++) leaf(8'(10 + k));
        check("credit_fifo_full_qready", query_ready, 0);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("credit_res_valid", res_valid, 1);
            check("credit_res_leaf", res_leaf, 10 + k);
            check("credit_res_id", res_id, k);
            tick();
        end
        res_ready = 1'b0;
        check("credit_drained", res_valid, 0);
        check("credit_resume", query_ready, 1);
`ifdef QUERY_PERF_CNT_EN
        check("perf_query_count", query_count, 9);
        check("perf_max_inflight", max_inflight, 4);
`endif

        check("no_error_yet", error, 0);
        leaf(8'd99);
        check("orphan_leaf_error", error, 1);
        check("orphan_leaf_no_res", res_valid, 0);

        query_valid = 1'b1; query_patch = pb; query_id = 4'd2;
        tick();
        query_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy_ignored", fsm_enable, 0);
        leaf(8'd7);
        pop(8'd7, 4'd2);

        query_valid = 1'b1; query_patch = pc; query_id = 4'd5;
        tick();
        query_id = 4'd6;
        tick();
        query_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_patch_en", tree_patch_en, 0);
        check("midrst_patch", tree_patch, 0);
        check("midrst_busy", busy, 0);
        check("midrst_error", error, 0);
        check("midrst_qready", query_ready, 0);
        check("midrst_fsm_en", fsm_enable, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle_qready", query_ready, 0);
        leaf(8'd1);
        leaf(8'd2);
        check("late_leaf_error", error, 1);
        check("late_leaf_no_res", res_valid, 0);
        tick();
        check("late_leaf_no_res2", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
